mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit owning the HI/LO register pair of the MIPS soft core. It sits directly downstream of the core's decode stage. The decoder issues mult/multu/div/divu/mthi/mtlo here, and mfhi/mflo read the `hi`/`lo` outputs. It trades speed for iCE40 area: one radix-2 step per clock, with no hardware multiplier block.

## Interface
Parameters:
- `WIDTH`, 32: operand width; only 32 is supported.

Ports:
- `clk`  in  1  core clock (the divided clock the CPU state machine runs on).
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `operand_a`  in  32  rs value (multiplicand / dividend).
- `operand_b`  in  32  rt value (multiplier / divisor).
- `hi_write`  in  1  mthi strobe.
- `lo_write`  in  1  mtlo strobe.
- `write_data`  in  32  rs value for mthi/mtlo.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; hi/lo valid.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE with `start`=1:
  - Latch `op`.
  - For signed ops (op[0]=0), latch the magnitudes of both operands plus a result-sign flag and a dividend-sign flag.
  - Load `step` = 31 and go to CALC.
- CALC, multiply: 64-bit accumulator with the shift-add algorithm on the unsigned magnitudes, one bit per clock.
- CALC, divide: restoring division with a 33-bit partial remainder, one quotient bit per clock.
- CALC exit: at `step`==0 go to FIXUP; otherwise `step` decrements.
- FIXUP: apply the sign correction and write the results, then go to IDLE.
  - Multiply: {hi,lo} = product, negated if the result sign is negative.
  - Divide: lo = quotient, negated if the operand signs differ. hi = remainder, taking the sign of the dividend.
- Divide by zero is decided, not undefined:
  - lo = 0xFFFF_FFFF and hi = operand_a, for both div and divu.
  - Detected at start, but the op still runs the full latency.
- Signed overflow (div 0x8000_0000 by 0xFFFF_FFFF): lo = 0x8000_0000, hi = 0.
- mthi/mtlo:
  - In IDLE, `hi_write`/`lo_write` load `write_data` on the next edge.
  - Both may fire together; both registers load.
- Simultaneous events:
  - `start` together with hi_write/lo_write in IDLE: start wins, the write is dropped.
  - `start`, hi_write or lo_write while busy: ignored. The core must stall on `busy`.
- `hi`/`lo` hold their last value through CALC. They change only in FIXUP or on an mthi/mtlo write.
- Reset (any state, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, step=0, accumulators=0. An op in flight is discarded with no done pulse.

## Timing
- `start` sampled at the end of cycle N:
  - `busy`=1 in cycles N+1..N+33.
  - `done`=1 and the new hi/lo are visible in cycle N+34.
  - `busy`=0 in cycle N+34.
- The latency is 34 cycles for all four ops, including divide by zero. There is no early termination.
- A new `start` is accepted in cycle N+34 (back-to-back).
- mthi/mtlo: 1-cycle latency. The value is visible the cycle after the strobe; `done` does not pulse.
- `done` is registered and high for exactly one cycle.
- Outputs are registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds:
  - `MD_OP_MULT`/`MD_OP_MULTU`/`MD_OP_DIV`/`MD_OP_DIVU` (2-bit).
  - `MD_STATE_IDLE`/`MD_STATE_CALC`/`MD_STATE_FIXUP`.
  - The core's existing ALU_OP_*/WB_* constants, moved there so the decoder and this block agree.
- Single module with no sub-modules.
- The datapath is one 65-bit shift register shared by multiply (accumulator) and divide (remainder:quotient). This keeps LUT count low.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF -> in cycle N+34: hi=0xFFFF_FFFE, lo=0x0000_0001, done for 1 cycle, busy for 33 cycles.
- mult 0xFFFF_FFFD (-3) × 7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- div -7 / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. divu 100 / 7 -> lo=14, hi=2.
- div by zero (div 5/0 and divu 5/0) -> lo=0xFFFF_FFFF, hi=5, after the full 34 cycles. div 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- mtlo 0x1234 while busy -> ignored, and the final lo is the op's result. mthi 0xABCD in IDLE -> hi=0xABCD the next cycle with no done. start+mtlo in the same IDLE cycle -> start wins.
- Reset asserted at cycle N+10 of a multu -> busy/done/hi/lo go to 0 immediately. No done afterwards, and the next start completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core constants for decoder and mult/div unit
package mips_pkg;

  // mult/div unit operation codes as issued by the decoder
  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_STATE_IDLE  = 2'd0,
    MD_STATE_CALC  = 2'd1,
    MD_STATE_FIXUP = 2'd2
  } md_state_e;

  // ALU operation select
  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_NOR  = 4'd5;
  localparam logic [3:0] ALU_OP_SLT  = 4'd6;
  localparam logic [3:0] ALU_OP_SLTU = 4'd7;
  localparam logic [3:0] ALU_OP_SLL  = 4'd8;
  localparam logic [3:0] ALU_OP_SRL  = 4'd9;
  localparam logic [3:0] ALU_OP_SRA  = 4'd10;
  localparam logic [3:0] ALU_OP_LUI  = 4'd11;

  // register write-back source select
  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_MEM  = 3'd1;
  localparam logic [2:0] WB_LINK = 3'd2;
  localparam logic [2:0] WB_HI   = 3'd3;
  localparam logic [2:0] WB_LO   = 3'd4;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide unit owning HI/LO
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;
  localparam int SW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_dvd_q, neg_dvd_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // shared shift register: {carry, hi, lo} for multiply, {remainder, quotient} for divide
  logic [AW-1:0]    acc_q, acc_d;

  // operand decode at issue
  logic             op_is_div, op_signed;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_is_div = (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  assign op_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
  assign a_mag = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign b_mag = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // multiply step: conditionally add multiplicand into the upper half, then shift right
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;

  assign mul_sum  = acc_q[AW-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

  // divide step: shift in next dividend bit, trial-subtract divisor, keep result if no borrow
  logic [WIDTH:0]   div_rem_sh, div_diff;
  logic             div_ok;
  logic [AW-1:0]    div_next;

  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = div_rem_sh - {1'b0, opnd_q};
  assign div_ok     = ~div_diff[WIDTH];
  assign div_next   = {(div_ok ? div_diff : div_rem_sh), acc_q[WIDTH-2:0], div_ok};

  // sign correction of the finished result; a zero divisor leaves the dividend as remainder
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign product  = neg_res_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
  assign quot_fix = dz_q ? {WIDTH{1'b1}}
                  : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_dvd_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // next-state and datapath control
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_dvd_d = neg_dvd_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    done_d    = 1'b0;

    case (state_q)
      MD_STATE_IDLE: begin
        if (start) begin
          div_d     = op_is_div;
          neg_res_d = op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          neg_dvd_d = op_signed && operand_a[WIDTH-1];
          dz_d      = op_is_div && (operand_b == '0);
          opnd_d    = op_is_div ? b_mag : a_mag;
          acc_d     = {{(WIDTH+1){1'b0}}, (op_is_div ? a_mag : b_mag)};
          step_d    = SW'(WIDTH - 1);
          state_d   = MD_STATE_CALC;
        end else begin
          if (hi_write) hi_d = write_data;
          if (lo_write) lo_d = write_data;
        end
      end
      MD_STATE_CALC: begin
        acc_d = div_q ? div_next : mul_next;
        if (step_q == '0) begin
          state_d = MD_STATE_FIXUP;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      MD_STATE_FIXUP: begin
        if (div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = product;
        end
        done_d  = 1'b1;
        state_d = MD_STATE_IDLE;
      end
      default: state_d = MD_STATE_IDLE;
    endcase
  end

  // state and datapath registers; reset discards any op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_STATE_IDLE;
      step_q    <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_dvd_q <= neg_dvd_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
    end
  end

  assign busy = (state_q != MD_STATE_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
